// File: rtl/fifo_40bit_arb_ctrl_if.sv
// Bus bundle for fifo_40bit_arb_ctrl: requester write ports, flush handshake,
// FIFO side-band and the output stream. master = controller view.
interface fifo_40bit_arb_ctrl_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 40,
  parameter int unsigned AW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clr_req;
  logic               clr_done;
  logic               fifo_we;
  logic [DW-1:0]      fifo_din;
  logic               fifo_re;
  logic               fifo_clr;
  logic [DW-1:0]      fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               m_valid;
  logic [DW-1:0]      m_data;
  logic               m_ready;
  logic [AW:0]        level;

  modport master (
    input  req_valid, req_data, clr_req, fifo_dout, fifo_full, fifo_empty, m_ready,
    output req_ready, clr_done, fifo_we, fifo_din, fifo_re, fifo_clr, m_valid, m_data, level
  );

  modport slave (
    output req_valid, req_data, clr_req, fifo_dout, fifo_full, fifo_empty, m_ready,
    input  req_ready, clr_done, fifo_we, fifo_din, fifo_re, fifo_clr, m_valid, m_data, level
  );
endinterface

// File: rtl/fifo_40bit_arb_ctrl.sv
// Round-robin write arbiter, 2-entry read prefetch and flush sequencer for a 256x40 FIFO.
// Optional occupancy counter enabled by defining FIFO_ARB_LEVEL_EN.
module fifo_40bit_arb_ctrl #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 40,
  parameter int unsigned AW   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_40bit_arb_ctrl_if.master bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned IW = PW + 1;
  localparam int unsigned LW = AW + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_CLR = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            inflight_q, inflight_d;
  logic [DW-1:0]   head_q, head_d;
  logic [DW-1:0]   tail_q, tail_d;
  logic            m_valid_q, m_valid_d;
  logic            fifo_clr_q, fifo_clr_d;
  logic            clr_done_q, clr_done_d;

  logic            run_c;
  logic            gfound_c;
  logic [PW-1:0]   gidx_c;
  logic [NREQ-1:0] grant_c;
  logic            we_c;
  logic            re_c;
  logic            pop_c;
  logic [1:0]      occ_c;
  logic [DW-1:0]   req_word [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign req_word[g] = bus.req_data[g*DW +: DW];
  end

  assign run_c = (state_q == ST_RUN) && !rst;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [IW-1:0] idx;
    idx      = '0;
    gfound_c = 1'b0;
    gidx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'(rr_ptr_q) + IW'(k);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!gfound_c && bus.req_valid[PW'(idx)]) begin
        gfound_c = 1'b1;
        gidx_c   = PW'(idx);
      end
    end
    grant_c = '0;
    if (run_c && !bus.fifo_full && gfound_c) grant_c[gidx_c] = 1'b1;
  end

  assign we_c  = |(bus.req_valid & grant_c);
  assign pop_c = m_valid_q & bus.m_ready;
  assign occ_c = cnt_q + {1'b0, inflight_q};
  // A pop this cycle frees a buffer slot in time for a read issued now.
  assign re_c  = run_c && !bus.fifo_empty && ((occ_c < 2'd2) || ((occ_c == 2'd2) && pop_c));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    inflight_d = re_c;
    head_d     = head_q;
    tail_d     = tail_q;
    fifo_clr_d = 1'b0;
    clr_done_d = 1'b0;

    case (state_q)
      ST_RUN: if (bus.clr_req) begin
        state_d    = ST_CLR;
        fifo_clr_d = 1'b1;
      end
      ST_CLR: begin
        state_d    = ST_RUN;
        clr_done_d = 1'b1;
      end
    endcase

    if (we_c) rr_ptr_d = (gidx_c == PW'(NREQ - 1)) ? '0 : gidx_c + PW'(1);

    // Returning read word enters behind any buffered word; pop shifts tail to head.
    case ({inflight_q, pop_c})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = bus.fifo_dout;
        else               tail_d = bus.fifo_dout;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = bus.fifo_dout;
        end else begin
          head_d = bus.fifo_dout;
        end
      end
      default: ;
    endcase

    if (state_q == ST_CLR) begin
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
    end
    m_valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      rr_ptr_q   <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      m_valid_q  <= 1'b0;
      fifo_clr_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      m_valid_q  <= m_valid_d;
      fifo_clr_q <= fifo_clr_d;
      clr_done_q <= clr_done_d;
    end
  end

`ifdef FIFO_ARB_LEVEL_EN
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (we_c && !re_c)      level_d = level_q + LW'(1);
    else if (!we_c && re_c) level_d = level_q - LW'(1);
    if (state_q == ST_CLR)  level_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign bus.level = level_q;
`else
  assign bus.level = '0;
`endif

  assign bus.req_ready = grant_c;
  assign bus.fifo_we   = we_c;
  assign bus.fifo_din  = req_word[gidx_c];
  assign bus.fifo_re   = re_c;
  assign bus.fifo_clr  = fifo_clr_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = head_q;
endmodule

// File: tb/tb_fifo_40bit_arb_ctrl.sv
// Bench for fifo_40bit_arb_ctrl: behavioural FIFO, word-level scoreboard and
// directed plus randomized traffic. Honours FIFO_ARB_LEVEL_EN like the design.
module tb_fifo_40bit_arb_ctrl;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 40;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_40bit_arb_ctrl_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus_if ();

  fifo_40bit_arb_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // External FIFO
  logic [DW-1:0] fq[$];
  logic [DW-1:0] dout_r = '0;

  // Reference: words accepted but not yet delivered, plus read-side bookkeeping
  logic [DW-1:0] sb[$];
  int exp_ptr     = 0;
  int outstanding = 0;
  int avail       = 0;
  bit re_prev     = 1'b0;
  bit in_clr      = 1'b0;
  bit done_exp    = 1'b0;

  // Per-cycle snapshot
  logic [NREQ-1:0] o_ready;
  int              o_gidx, exp_gi;
  bit              o_we, o_re, o_clr, o_done, o_mvalid, o_full, o_pop, o_mpop, o_rst, o_clr_req, o_exp_re;
  logic [DW-1:0]   o_mdata, o_din, o_word;
  logic [AW:0]     o_level;
  int              hs_total  = 0;
  int              pop_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = (r < 0) ? i : -2;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic set_data_random();
    for (int i = 0; i < NREQ; i++) bus_if.req_data[i*DW +: DW] = rand_word();
  endtask

  task automatic sample_check();
    logic [NREQ-1:0] eg;
    bit exp_re, exp_mv;
    int gi;
    gi = -1;
    eg = '0;
    if (!rst && !in_clr && !bus_if.fifo_full)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = int'((exp_ptr + k) % NREQ);
        if (gi < 0 && bus_if.req_valid[i]) gi = i;
      end
    if (gi >= 0) eg[gi] = 1'b1;
    exp_mv = (avail != 0);
    exp_re = !rst && !in_clr && !bus_if.fifo_empty &&
             (outstanding < 2 || (outstanding == 2 && exp_mv && bus_if.m_ready));

    check("req_ready", 64'(bus_if.req_ready), 64'(eg));
    check("fifo_we", 64'(bus_if.fifo_we), 64'(gi >= 0));
    if (gi >= 0) check("fifo_din", 64'(bus_if.fifo_din), 64'(bus_if.req_data[gi*DW +: DW]));
    check("fifo_re", 64'(bus_if.fifo_re), 64'(exp_re));
    check("m_valid", 64'(bus_if.m_valid), 64'(exp_mv));
    if (exp_mv) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) check("m_data", 64'(bus_if.m_data), 64'(sb[0]));
    end
    check("fifo_clr", 64'(bus_if.fifo_clr), 64'(in_clr));
    check("clr_done", 64'(bus_if.clr_done), 64'(done_exp));
`ifdef FIFO_ARB_LEVEL_EN
    check("level", 64'(bus_if.level), 64'(fq.size()));
`else
    check("level", 64'(bus_if.level), 64'(0));
`endif

    o_ready   = bus_if.req_ready;
    o_gidx    = onehot_idx(bus_if.req_ready);
    o_we      = bus_if.fifo_we;
    o_re      = bus_if.fifo_re;
    o_din     = bus_if.fifo_din;
    o_clr     = bus_if.fifo_clr;
    o_done    = bus_if.clr_done;
    o_mvalid  = bus_if.m_valid;
    o_mdata   = bus_if.m_data;
    o_level   = bus_if.level;
    o_full    = bus_if.fifo_full;
    o_mpop    = bus_if.m_valid && bus_if.m_ready;
    o_pop     = exp_mv && bus_if.m_ready;
    o_rst     = rst;
    o_clr_req = bus_if.clr_req;
    o_exp_re  = exp_re;
    exp_gi    = gi;
    o_word    = (gi >= 0) ? bus_if.req_data[gi*DW +: DW] : '0;
    if (o_we) hs_total++;
    if (o_mpop) pop_total++;
  endtask

  task automatic commit();
    int sz0;
    sz0 = fq.size();
    if (o_rst) begin
      fq.delete();
      dout_r = '0;
    end else if (o_clr) begin
      fq.delete();
    end else begin
      if (o_re && sz0 > 0) dout_r = fq.pop_front();
      if (o_we && sz0 < DEPTH) fq.push_back(o_din);
    end

    if (o_rst) begin
      sb.delete();
      exp_ptr = 0; outstanding = 0; avail = 0;
      re_prev = 1'b0; in_clr = 1'b0; done_exp = 1'b0;
    end else if (in_clr) begin
      sb.delete();
      outstanding = 0; avail = 0;
      re_prev = 1'b0; in_clr = 1'b0; done_exp = 1'b1;
    end else begin
      if (o_pop && sb.size() != 0) void'(sb.pop_front());
      if (exp_gi >= 0) begin
        sb.push_back(o_word);
        exp_ptr = (exp_gi + 1) % NREQ;
      end
      outstanding = outstanding + int'(o_exp_re) - int'(o_pop);
      avail       = avail + int'(re_prev) - int'(o_pop);
      re_prev     = o_exp_re;
      in_clr      = o_clr_req;
      done_exp    = 1'b0;
    end

    bus_if.fifo_full  = (fq.size() >= DEPTH);
    bus_if.fifo_empty = (fq.size() == 0);
    bus_if.fifo_dout  = dout_r;
  endtask

  task automatic step();
    @(negedge clk);
    sample_check();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic drain();
    int n = 0;
    bus_if.req_valid = '0;
    bus_if.m_ready   = 1'b1;
    bus_if.clr_req   = 1'b0;
    while ((sb.size() != 0 || fq.size() != 0) && n < 700) begin
      step();
      n++;
    end
    check("drain_done", 64'(sb.size() + fq.size()), 64'(0));
  endtask

  initial begin
    int n, stale;
    rst               = 1'b1;
    bus_if.req_valid  = '1;
    bus_if.clr_req    = 1'b0;
    bus_if.m_ready    = 1'b0;
    bus_if.fifo_full  = 1'b0;
    bus_if.fifo_empty = 1'b1;
    bus_if.fifo_dout  = '0;
    set_data_random();
    step();
    step();
    check("rst_ready", 64'(o_ready), 64'(0));
    check("rst_m_valid", 64'(o_mvalid), 64'(0));
    check("rst_m_data", 64'(o_mdata), 64'(0));
    check("rst_level", 64'(o_level), 64'(0));
    check("rst_clr_done", 64'(o_done), 64'(0));
    check("rst_fifo_clr", 64'(o_clr), 64'(0));

    // Fairness with all requesters active
    rst = 1'b0;
    bus_if.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_data_random();
      step();
      check("fair_grant", 64'(o_gidx), 64'(c % NREQ));
    end
    drain();

    // Latency and ordering into an empty system
    bus_if.req_valid = 4'b0100;
    bus_if.req_data[2*DW +: DW] = 40'h00000000AA;
    step();
    check("lat_we", 64'(o_we), 64'(1));
    bus_if.req_data[2*DW +: DW] = 40'h00000000BB;
    step();
    check("lat_re", 64'(o_re), 64'(1));
    bus_if.req_valid = '0;
    step();
    check("lat_mv_c2", 64'(o_mvalid), 64'(0));
    step();
    check("lat_mv_c3", 64'(o_mvalid), 64'(1));
    check("lat_data_c3", 64'(o_mdata), 64'(40'hAA));
    step();
    check("lat_mv_c4", 64'(o_mvalid), 64'(1));
    check("lat_data_c4", 64'(o_mdata), 64'(40'hBB));
    drain();

    // Fill until full with the consumer stalled
    bus_if.req_valid = 4'b0001;
    bus_if.m_ready   = 1'b0;
    hs_total = 0;
    for (int c = 0; c < 300; c++) begin
      set_data_random();
      step();
    end
    check("full_writes", 64'(hs_total), 64'(DEPTH + 2));
    check("full_ready", 64'(o_ready), 64'(0));
    check("full_flag", 64'(o_full), 64'(1));
`ifdef FIFO_ARB_LEVEL_EN
    check("full_level", 64'(o_level), 64'(DEPTH));
`else
    check("full_level", 64'(o_level), 64'(0));
`endif
    hs_total = 0;
    bus_if.m_ready = 1'b1;
    step();
    bus_if.m_ready = 1'b0;
    repeat (10) step();
    check("full_one_more", 64'(hs_total), 64'(1));
    drain();

    // Alternating backpressure over 20 words
    bus_if.req_valid = 4'b0010;
    hs_total = 0; pop_total = 0; n = 0;
    while (hs_total < 20 && n < 200) begin
      bus_if.m_ready = (n % 2 == 0);
      set_data_random();
      step();
      n++;
    end
    bus_if.req_valid = '0;
    while (pop_total < 20 && n < 400) begin
      bus_if.m_ready = (n % 2 == 0);
      step();
      n++;
    end
    check("bp_writes", 64'(hs_total), 64'(20));
    check("bp_delivered", 64'(pop_total), 64'(20));
    check("bp_sb_empty", 64'(sb.size()), 64'(0));
    drain();

    // Flush with the buffer full and a read going out in the request cycle
    bus_if.req_valid = 4'b1000;
    bus_if.m_ready   = 1'b0;
    repeat (6) begin set_data_random(); step(); end
    bus_if.m_ready = 1'b1;
    bus_if.clr_req = 1'b1;
    step();
    check("flush_req_re", 64'(o_re), 64'(1));
    bus_if.m_ready = 1'b0;
    step();
    check("flush_clr", 64'(o_clr), 64'(1));
    check("flush_no_we", 64'(o_we), 64'(0));
    check("flush_no_re", 64'(o_re), 64'(0));
    bus_if.clr_req   = 1'b0;
    bus_if.req_valid = '0;
    step();
    check("flush_done", 64'(o_done), 64'(1));
    check("flush_m_valid", 64'(o_mvalid), 64'(0));
    check("flush_level", 64'(o_level), 64'(0));
    check("flush_clr_once", 64'(o_clr), 64'(0));
    bus_if.m_ready = 1'b1;
    stale = 0;
    repeat (6) begin step(); if (o_mvalid) stale++; end
    check("flush_stale", 64'(stale), 64'(0));

    // Reset during traffic
    for (int c = 0; c < 20; c++) begin
      bus_if.req_valid = NREQ'($urandom());
      bus_if.m_ready   = $urandom_range(1, 0) != 0;
      set_data_random();
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.req_valid = '1;
    step();
    check("rst_mid_ptr", 64'(o_gidx), 64'(0));
    check("rst_mid_m_valid", 64'(o_mvalid), 64'(0));
    check("rst_mid_level", 64'(o_level), 64'(0));
    check("rst_mid_clr_done", 64'(o_done), 64'(0));
    drain();

    // Randomized traffic, alternating light and heavy consumer stalls
    for (int c = 0; c < 3000; c++) begin
      bus_if.req_valid = NREQ'($urandom());
      set_data_random();
      bus_if.m_ready = ((c / 500) % 2 == 1) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      bus_if.clr_req = ($urandom_range(149, 0) == 0);
      rst            = ($urandom_range(699, 0) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
